// File: rtl/stopwatch_tick_ctrl_if.sv
// Stopwatch control bus: raw user buttons in, timebase/clear strobes and FSM status out.
// master = the tick controller, slave = whoever drives the buttons and consumes the strobes.
interface stopwatch_tick_ctrl_if;
  logic       btn_start_stop;
  logic       btn_clear;
  logic       tick;
  logic       count_clr;
  logic       running;
  logic [1:0] state;

  modport master (
    input  btn_start_stop,
    input  btn_clear,
    output tick,
    output count_clr,
    output running,
    output state
  );

  modport slave (
    output btn_start_stop,
    output btn_clear,
    input  tick,
    input  count_clr,
    input  running,
    input  state
  );
endinterface

// File: rtl/stopwatch_tick_ctrl.sv
// Run/pause/clear controller and timebase for the stopwatch.
// Buttons are synchronized, optionally debounced, and edge-detected into one-cycle
// press events that drive an IDLE/RUN/PAUSE FSM. A prescaler divides clk_i into a
// one-cycle tick strobe while running; count_clr zeroes the downstream counters.
// Optional feature: define STOPWATCH_DEBOUNCE_EN to insert a DB_CYCLES debouncer.
module stopwatch_tick_ctrl #(
  parameter int unsigned DIV       = 50000000,
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  stopwatch_tick_ctrl_if.master bus
);

  localparam int unsigned PW = $clog2(DIV);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_e;

  // Index 0 = start/stop, index 1 = clear
  logic [1:0] btn_raw;
  logic [1:0] btn_evt;
  logic       ss_evt;
  logic       clr_evt;

  assign btn_raw = {bus.btn_clear, bus.btn_start_stop};
  assign ss_evt  = btn_evt[0];
  assign clr_evt = btn_evt[1];

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int unsigned DBW = $clog2(DB_CYCLES + 1);
`else
  logic [31:0] unused_db_cycles;
  assign unused_db_cycles = 32'(DB_CYCLES);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic sync1_q;
      logic sync2_q;
      logic level;
      logic level_prev_q;

      // Two-flop synchronizer for the asynchronous raw button
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
        end else begin
          sync1_q <= btn_raw[gi];
          sync2_q <= sync1_q;
        end
      end

`ifdef STOPWATCH_DEBOUNCE_EN
      logic [DBW-1:0] db_cnt_q;
      logic           db_level_q;

      // Adopt a new level only after DB_CYCLES consecutive samples disagree with the current one
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          db_cnt_q   <= '0;
          db_level_q <= 1'b0;
        end else if (sync2_q == db_level_q) begin
          db_cnt_q <= '0;
        end else if (db_cnt_q == DBW'(DB_CYCLES - 1)) begin
          db_level_q <= sync2_q;
          db_cnt_q   <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + DBW'(1);
        end
      end

      assign level = db_level_q;
`else
      assign level = sync2_q;
`endif

      // Remember last conditioned level so a held button yields a single event
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          level_prev_q <= 1'b0;
        end else begin
          level_prev_q <= level;
        end
      end

      assign btn_evt[gi] = level & ~level_prev_q;
    end
  endgenerate

  state_e        state_q;
  logic [PW-1:0] p_q;
  logic [PW-1:0] p_d;
  logic          p_wrap;
  logic          tick_q;
  logic          count_clr_q;
  logic          running_q;

  assign p_wrap = (p_q == PW'(DIV - 1));

  // Prescaler advance with exact wrap at DIV-1 so the tick period never drifts
  always_comb begin
    p_d = p_q + PW'(1);
    if (p_wrap) begin
      p_d = '0;
    end
  end

  // Control FSM, prescaler and registered strobes; clear beats start/stop except in RUN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      p_q         <= '0;
      tick_q      <= 1'b0;
      count_clr_q <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      tick_q      <= 1'b0;
      count_clr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          p_q <= '0;
          if (clr_evt) begin
            count_clr_q <= 1'b1;
          end else if (ss_evt) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
          end
        end
        S_RUN: begin
          // Tick and wrap still happen on the cycle we leave for PAUSE
          p_q    <= p_d;
          tick_q <= p_wrap;
          if (ss_evt) begin
            state_q   <= S_PAUSE;
            running_q <= 1'b0;
          end
        end
        S_PAUSE: begin
          if (clr_evt) begin
            state_q     <= S_IDLE;
            count_clr_q <= 1'b1;
            p_q         <= '0;
          end else if (ss_evt) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          p_q       <= '0;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tick      = tick_q;
  assign bus.count_clr = count_clr_q;
  assign bus.running   = running_q;
  assign bus.state     = state_q;

endmodule

// File: doc/stopwatch_tick_ctrl.md
# stopwatch_tick_ctrl

Run/pause/clear controller and timebase for the stopwatch. Conditions the two user buttons, runs a three-state control FSM, and divides CLK down to a one-cycle `tick` strobe that advances the downstream seconds/minutes mod-60 counters. Also issues `count_clr` to zero those counters. Sits directly upstream of the counter chain.

## Interface
- `DIV`, 50000000: CLK cycles per tick; legal range DIV ≥ 2.
- `DB_CYCLES`, 1000000: debounce stability window in CLK cycles (used only with `DEBOUNCE_EN`); DB_CYCLES ≥ 1.
- `CLK`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  synchronous active-high reset.
- `btn_start_stop`  in  1  asynchronous raw button, active-high.
- `btn_clear`  in  1  asynchronous raw button, active-high.
- `tick`  out  1  one-cycle timebase strobe, registered.
- `count_clr`  out  1  one-cycle clear strobe to the downstream counters, registered.
- `running`  out  1  high while in RUN.
- `state`  out  2  FSM state: IDLE=00, RUN=01, PAUSE=10; 11 is unreachable.

## Operation
- Each button passes through a 2-flop synchronizer, then (optionally) a debouncer, then a rising-edge detector. Each detector produces a one-cycle press event: `ss_evt` or `clr_evt`.
- Prescaler `p`: a $clog2(DIV)-bit counter.
  - Increments only in RUN.
  - Wraps from DIV-1 to 0.
  - Holds its value in PAUSE.
  - Is forced to 0 in IDLE.
- `tick` is set for exactly one cycle after each cycle in which state is RUN and p == DIV-1.
- FSM transitions:
  - IDLE: `ss_evt` → RUN. `clr_evt` → stay IDLE and pulse `count_clr`.
  - RUN: `ss_evt` → PAUSE. `clr_evt` is ignored.
  - PAUSE: `ss_evt` → RUN, resuming from the retained p. `clr_evt` → IDLE, pulse `count_clr`, and zero p.
- Simultaneous events:
  - In IDLE and PAUSE, `clr_evt` wins over `ss_evt`.
  - In RUN, `ss_evt` is honoured and `clr_evt` is dropped.
- If RUN→PAUSE happens in the same cycle that p == DIV-1, the tick is still emitted and p wraps to 0 before holding.
- Holding a button produces a single event. A new event requires a release followed by a new press.
- Reset values: state=IDLE, p=0, tick=0, count_clr=0, running=0. Synchronizer and debounce flops reset to 0.
- Reset mid-operation aborts everything on that edge. No tick or count_clr is issued as a result of the reset; the downstream counters are reset by their own reset.

## Timing
- Button to state (without debounce): a button first sampled high at edge k gives a state change visible after edge k+2.
- `count_clr` rises on the same edge as the state change caused by `clr_evt`.
- `running` and `state` are registered and change on the same edge.
- First tick after IDLE→RUN at edge t: tick is high in the cycle after edge t+DIV. Subsequent ticks follow every DIV cycles.
- After PAUSE→RUN, the next tick arrives after DIV-1-p_held+1 cycles.
- Tick period is exact. There is no drift at the wrap point.

## Configuration
- `STOPWATCH_DEBOUNCE_EN` defined:
  - Each synchronized button must hold a new level for DB_CYCLES consecutive cycles before the debounced level changes.
  - The press event fires on the rising edge of the debounced level.
  - Button-to-state latency becomes DB_CYCLES+2 edges.
  - Glitches shorter than DB_CYCLES cycles produce no event.
- Not defined: debounce logic is absent, and the edge detector operates directly on the synchronizer output.

## Test plan
- **Reset and idle:** rst high for 2 cycles, then low; no buttons for 20 cycles → state=00, tick=0, count_clr=0, running=0 throughout.
- **Basic run (DIV=4):** start pulse → state=01 two edges after sampling; ticks at cycles DIV, 2·DIV, 3·DIV after entry; exactly 1 cycle high each.
- **Pause/resume:** DIV=4; pause with p=2 → no ticks for 10 cycles. Resume → first tick after 2 cycles, then every 4 cycles.
- **Clear handling:**
  - Clear in RUN is ignored (count_clr stays 0).
  - Clear in PAUSE → state=00, count_clr=1 for one cycle, p=0.
  - Simultaneous start+clear in PAUSE → IDLE.
- **Debounce (`STOPWATCH_DEBOUNCE_EN`, DB_CYCLES=3):**
  - A 2-cycle glitch on btn_start_stop causes no state change.
  - A 5-cycle press → RUN exactly 5 edges after first sampling.
  - A held button produces one event only.
- **Reset mid-run:** rst asserted while p=DIV-1 → next cycle tick=0, state=00, p=0.
